// File: rtl/cvxif_result_queue.sv
// CVXIF result buffer: decouples coprocessor write-back results from the core
// result port through a DEPTH-entry FIFO. Its output depends only on registered state.

module cvxif_rq_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  q <= '0;
    else if (we)  q <= d;
  end
endmodule

module cvxif_result_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned XLEN     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       cop_result_valid_i,
  output logic                       cop_result_ready_o,
  input  logic [ID_WIDTH-1:0]        cop_result_id_i,
  input  logic [XLEN-1:0]            cop_result_data_i,
  input  logic [4:0]                 cop_result_rd_i,
  input  logic                       cop_result_we_i,
  output logic                       core_result_valid_o,
  input  logic                       core_result_ready_i,
  output logic [ID_WIDTH-1:0]        core_result_id_o,
  output logic [XLEN-1:0]            core_result_data_o,
  output logic [4:0]                 core_result_rd_o,
  output logic                       core_result_we_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     data;
    logic [4:0]          rd;
    logic                we;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t                     wr_entry, head;
  logic [DEPTH-1:0][EW-1:0]   mem;
  logic [DEPTH-1:0]           slot_we;
  logic [PTR_W-1:0]           wptr, rptr;
  logic [CNT_W-1:0]           usage;
  logic                       push, pop;

  assign full_o  = (usage == CNT_W'(DEPTH));
  assign empty_o = (usage == '0);
  assign usage_o = usage;

  assign cop_result_ready_o  = !full_o;
  assign core_result_valid_o = !empty_o;

  assign push = cop_result_valid_i & cop_result_ready_o;
  assign pop  = core_result_valid_o & core_result_ready_i;

  assign wr_entry = '{id: cop_result_id_i, data: cop_result_data_i,
                      rd: cop_result_rd_i, we: cop_result_we_i};

  // A flushed push is never written, so a dropped result cannot resurface.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign slot_we[g] = push && !flush_i && (wptr == PTR_W'(g));
      cvxif_rq_entry #(.W(EW)) u_entry (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (slot_we[g]),
        .d     (wr_entry),
        .q     (mem[g])
      );
    end
  endgenerate

  assign head                = entry_t'(mem[rptr]);
  assign core_result_id_o    = head.id;
  assign core_result_data_o  = head.data;
  assign core_result_rd_o    = head.rd;
  assign core_result_we_o    = head.we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      usage <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      usage <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   usage <= usage + CNT_W'(1);
        2'b01:   usage <= usage - CNT_W'(1);
        default: usage <= usage;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_usage_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    usage <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && usage == '0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !full_o);
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (core_result_valid_o && !core_result_ready_i && !flush_i)
      |=> (core_result_valid_o && $stable(head)));
`endif

endmodule
